// File: rtl/bsg_cache_sbuf_drain_if.sv
// Store-buffer pop handshake and data SRAM write port of the sbuf drain.
// The master modport is the drain engine; the slave side is its environment.
interface bsg_cache_sbuf_drain_if #(
  parameter int data_width_p          = 32,
  parameter int addr_width_p          = 28,
  parameter int ways_p                = 2,
  parameter int sets_p                = 64,
  parameter int block_size_in_words_p = 8
);
  localparam int mask_w  = data_width_p / 8;
  localparam int lg_ways = (ways_p > 2) ? $clog2(ways_p) : 1;
  localparam int entry_w = addr_width_p + data_width_p + mask_w + lg_ways;
  localparam int idx_w   = $clog2(sets_p) + $clog2(block_size_in_words_p);

  logic [entry_w-1:0]             sbuf_entry_i;
  logic                           v_i;
  logic                           yumi_o;
  logic                           data_mem_v_o;
  logic                           data_mem_w_o;
  logic [idx_w-1:0]               data_mem_addr_o;
  logic [data_width_p*ways_p-1:0] data_mem_data_o;
  logic [mask_w*ways_p-1:0]       data_mem_w_mask_o;
  logic                           data_mem_ready_i;

  modport master (
    input  sbuf_entry_i, v_i, data_mem_ready_i,
    output yumi_o, data_mem_v_o, data_mem_w_o,
    output data_mem_addr_o, data_mem_data_o,
    output data_mem_w_mask_o
  );

  modport slave (
    output sbuf_entry_i, v_i, data_mem_ready_i,
    input  yumi_o, data_mem_v_o, data_mem_w_o,
    input  data_mem_addr_o, data_mem_data_o,
    input  data_mem_w_mask_o
  );
endinterface

// File: rtl/bsg_cache_sbuf_drain.sv
// Store buffer drain: skid-staged masked writes into the shared data SRAM,
// plus a flush handshake that reports when all buffered stores are committed.
module bsg_cache_sbuf_drain #(
  parameter int data_width_p          = 32,
  parameter int addr_width_p          = 28,
  parameter int ways_p                = 2,
  parameter int sets_p                = 64,
  parameter int block_size_in_words_p = 8,
  parameter int count_width_p         = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     sbuf_empty_i,
  input  logic                     flush_i,
  output logic                     flush_done_o,
  output logic [count_width_p-1:0] write_count_o,
  bsg_cache_sbuf_drain_if.master   bus
);
  localparam int mask_w  = data_width_p / 8;
  localparam int lg_ways = (ways_p > 2) ? $clog2(ways_p) : 1;
  localparam int idx_w   = $clog2(sets_p) + $clog2(block_size_in_words_p);
  localparam int off_w   = $clog2(mask_w);
  localparam int row_d_w = data_width_p * ways_p;
  localparam int row_m_w = mask_w * ways_p;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSHING,
    S_DONE
  } state_e;

  logic [addr_width_p-1:0] e_addr;
  logic [data_width_p-1:0] e_data;
  logic [mask_w-1:0]       e_mask;
  logic [lg_ways-1:0]      e_way;
  logic [idx_w-1:0]        e_row;
  logic [row_m_w-1:0]      e_mask_sh;
  logic                    unused_addr_bits;

  assign {e_addr, e_data, e_mask, e_way} = bus.sbuf_entry_i;
  assign e_row = e_addr[off_w +: idx_w];
  assign e_mask_sh = row_m_w'(e_mask) << (e_way * mask_w);
  assign unused_addr_bits = ^{e_addr[addr_width_p-1:off_w+idx_w],
                              e_addr[off_w-1:0]};

  logic                     stage_v_q, stage_v_d;
  logic [idx_w-1:0]         row_q, row_d;
  logic [data_width_p-1:0]  data_q, data_d;
  logic [row_m_w-1:0]       mask_q, mask_d;
  logic [count_width_p-1:0] count_q, count_d;
  state_e                   state_q, state_d;
  logic                     fire;
  logic                     yumi;
  logic                     drained;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_v_q <= 1'b0;
      row_q     <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
    end else begin
      stage_v_q <= stage_v_d;
      row_q     <= row_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      state_q   <= state_d;
    end
  end

  // Gated by reset so nothing is popped while the engine is held in reset.
  always_comb begin
    fire      = stage_v_q & bus.data_mem_ready_i;
    yumi      = reset_n_i & bus.v_i & (~stage_v_q | fire);
    stage_v_d = stage_v_q;
    row_d     = row_q;
    data_d    = data_q;
    mask_d    = mask_q;
    count_d   = count_q + {{(count_width_p-1){1'b0}}, fire};
    if (yumi) begin
      stage_v_d = |e_mask;
      if (|e_mask) begin
        row_d  = e_row;
        data_d = e_data;
        mask_d = e_mask_sh;
      end
    end else if (fire) begin
      stage_v_d = 1'b0;
    end
  end

  always_comb begin
    drained      = ~stage_v_q & ~bus.v_i & sbuf_empty_i;
    state_d      = state_q;
    flush_done_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) state_d = S_FLUSHING;
      end
      S_FLUSHING: begin
        if (drained) state_d = S_DONE;
      end
      S_DONE: begin
        flush_done_o = 1'b1;
        state_d = flush_i ? S_FLUSHING : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.yumi_o            = yumi;
  assign bus.data_mem_v_o      = stage_v_q;
  assign bus.data_mem_w_o      = stage_v_q;
  assign bus.data_mem_addr_o   = row_q;
  assign bus.data_mem_data_o   = {ways_p{data_q}};
  assign bus.data_mem_w_mask_o = mask_q;
  assign write_count_o         = count_q;

  logic unused_row_d_w;
  assign unused_row_d_w = (row_d_w == 0);
endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// Directed bench for the sbuf drain with a per-cycle reference model
// of the pop handshake, pending write, write counter and flush handshake.
module tb_bsg_cache_sbuf_drain;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sbuf_empty = 1'b1;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [15:0] write_count;

  int n_tests = 0;
  int n_fail  = 0;

  bsg_cache_sbuf_drain_if #(
    .data_width_p(32), .addr_width_p(28), .ways_p(2),
    .sets_p(64), .block_size_in_words_p(8)
  ) bus ();

  bsg_cache_sbuf_drain #(
    .data_width_p(32), .addr_width_p(28), .ways_p(2),
    .sets_p(64), .block_size_in_words_p(8), .count_width_p(16)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .sbuf_empty_i(sbuf_empty),
    .flush_i(flush),
    .flush_done_o(flush_done),
    .write_count_o(write_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [64:0] mk(input logic [27:0] a,
                                     input logic [31:0] d,
                                     input logic [3:0] m,
                                     input logic w);
    return {a, d, m, w};
  endfunction

  // Reference model: at most one accepted-but-unwritten store.
  logic        m_pend;
  int          m_row;
  logic [63:0] m_data;
  logic [7:0]  m_mask;
  logic [15:0] m_cnt;
  int          m_fs;

  always @(negedge clk) begin
    logic e_yumi, e_fire, drained;
    logic [27:0] a;
    logic [31:0] d;
    logic [3:0]  mk4;
    if (!rst_n) begin
      m_pend = 1'b0;
      m_cnt  = 16'd0;
      m_fs   = 0;
      chk("rst_yumi", bus.yumi_o, 0);
      chk("rst_v", bus.data_mem_v_o, 0);
      chk("rst_done", flush_done, 0);
      chk("rst_cnt", write_count, 0);
    end else begin
      e_fire = m_pend & bus.data_mem_ready_i;
      e_yumi = bus.v_i & (!m_pend | e_fire);
      chk("m_yumi", bus.yumi_o, e_yumi);
      chk("m_v", bus.data_mem_v_o, m_pend);
      chk("m_w", bus.data_mem_w_o, m_pend);
      if (m_pend) begin
        chk("m_addr", bus.data_mem_addr_o, m_row);
        chk("m_data", bus.data_mem_data_o, m_data);
        chk("m_mask", bus.data_mem_w_mask_o, m_mask);
      end
      chk("m_cnt", write_count, m_cnt);
      chk("m_done", flush_done, m_fs == 2);
      drained = !m_pend & !bus.v_i & sbuf_empty;
      case (m_fs)
        0: if (flush) m_fs = 1;
        1: if (drained) m_fs = 2;
        default: m_fs = flush ? 1 : 0;
      endcase
      if (e_yumi) begin
        {a, d, mk4} = bus.sbuf_entry_i[64:1];
        m_pend = (mk4 != 4'h0);
        if (m_pend) begin
          m_row  = (int'(a) / 4) % 512;
          m_data = {d, d};
          m_mask = 8'(mk4) << (bus.sbuf_entry_i[0] ? 4 : 0);
        end
      end else if (e_fire) begin
        m_pend = 1'b0;
      end
      if (e_fire) m_cnt = m_cnt + 16'd1;
    end
  end

  task automatic drive(input logic v, input logic [64:0] e,
                       input logic rdy, input logic fl,
                       input logic emp);
    @(posedge clk);
    #1;
    bus.v_i = v;
    bus.sbuf_entry_i = e;
    bus.data_mem_ready_i = rdy;
    flush = fl;
    sbuf_empty = emp;
  endtask

  logic [64:0] ents [3];
  int idx;
  bit done_seen;

  initial begin
    bus.v_i = 1'b1;
    bus.sbuf_entry_i = mk(28'h104, 32'h1, 4'hF, 1'b0);
    bus.data_mem_ready_i = 1'b1;
    @(negedge clk);
    chk("reset_yumi_gated", bus.yumi_o, 0);
    chk("reset_v", bus.data_mem_v_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.v_i = 1'b0;

    // single write
    drive(1, mk(28'h104, 32'hDEADBEEF, 4'hF, 1), 1, 0, 1);
    @(negedge clk); chk("single_yumi", bus.yumi_o, 1);
    drive(0, '0, 1, 0, 1);
    @(negedge clk);
    chk("single_v", bus.data_mem_v_o, 1);
    chk("single_addr", bus.data_mem_addr_o, 64'h041);
    chk("single_data", bus.data_mem_data_o, 64'hDEADBEEF_DEADBEEF);
    chk("single_mask", bus.data_mem_w_mask_o, 64'hF0);
    drive(0, '0, 1, 0, 1);
    @(negedge clk); chk("single_cnt", write_count, 1);

    // backpressure
    drive(1, mk(28'h208, 32'h11111111, 4'h3, 0), 0, 0, 0);
    @(negedge clk); chk("bp_yumi_a", bus.yumi_o, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, mk(28'h20C, 32'h22222222, 4'hC, 1), 0, 0, 0);
      @(negedge clk);
      chk("bp_yumi_b_held", bus.yumi_o, 0);
      chk("bp_addr_stable", bus.data_mem_addr_o, 64'h082);
      chk("bp_mask_stable", bus.data_mem_w_mask_o, 64'h03);
    end
    drive(1, mk(28'h20C, 32'h22222222, 4'hC, 1), 1, 0, 0);
    @(negedge clk); chk("bp_yumi_b", bus.yumi_o, 1);
    drive(0, '0, 1, 0, 1);
    @(negedge clk);
    chk("bp_addr_b", bus.data_mem_addr_o, 64'h083);
    chk("bp_mask_b", bus.data_mem_w_mask_o, 64'hC0);
    drive(0, '0, 1, 0, 1);
    @(negedge clk); chk("bp_cnt", write_count, 3);

    // zero mask
    drive(1, mk(28'h300, 32'h12345678, 4'h0, 0), 1, 0, 0);
    @(negedge clk); chk("zm_yumi", bus.yumi_o, 1);
    drive(1, mk(28'h010, 32'hCAFEF00D, 4'h3, 0), 1, 0, 0);
    @(negedge clk); chk("zm_no_write", bus.data_mem_v_o, 0);
    drive(0, '0, 1, 0, 1);
    @(negedge clk);
    chk("zm_mask", bus.data_mem_w_mask_o, 64'h03);
    chk("zm_addr", bus.data_mem_addr_o, 64'h004);
    drive(0, '0, 1, 0, 1);
    @(negedge clk); chk("zm_cnt", write_count, 4);

    // flush while empty
    drive(0, '0, 1, 1, 1);
    @(negedge clk); chk("fe_done_c0", flush_done, 0);
    drive(0, '0, 1, 0, 1);
    @(negedge clk); chk("fe_done_c1", flush_done, 0);
    drive(0, '0, 1, 0, 1);
    @(negedge clk); chk("fe_done_c2", flush_done, 1);
    drive(0, '0, 1, 0, 1);
    @(negedge clk); chk("fe_done_c3", flush_done, 0);

    // flush with pending stores
    ents[0] = mk(28'h400, 32'hA0A0A0A0, 4'h1, 0);
    ents[1] = mk(28'h404, 32'hB1B1B1B1, 4'h8, 1);
    ents[2] = mk(28'h408, 32'hC2C2C2C2, 4'hF, 0);
    idx = 0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 3) drive(1, ents[idx], c % 2 == 0, c == 0, 0);
      else drive(0, '0, c % 2 == 0, 0, 1);
      @(negedge clk);
      if (bus.yumi_o) idx++;
      if (flush_done) begin
        done_seen = 1;
        chk("fp_cnt_at_done", write_count, 7);
        break;
      end
    end
    chk("fp_done_seen", done_seen, 1);
    drive(0, '0, 1, 0, 1);
    @(negedge clk); chk("fp_single_pulse", flush_done, 0);

    // reset mid-operation
    drive(1, mk(28'h500, 32'h55555555, 4'hF, 0), 0, 1, 0);
    @(negedge clk); chk("rm_yumi", bus.yumi_o, 1);
    drive(0, '0, 0, 1, 1);
    @(negedge clk); chk("rm_staged", bus.data_mem_v_o, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rm_v_drop", bus.data_mem_v_o, 0);
    chk("rm_done_low", flush_done, 0);
    chk("rm_cnt_zero", write_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush = 1'b0;
    bus.data_mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rm_no_write", bus.data_mem_v_o, 0);
      chk("rm_no_done", flush_done, 0);
    end
    chk("rm_cnt_after", write_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
